// File: rtl/sram_pkg.sv
// Shared types and elaboration helpers for the masked-write 1RW SRAM with clear-on-reset.
package sram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } sram_state_e;

    function automatic int seg_w(input int data_w, input int mask_w);
        return data_w / mask_w;
    endfunction

    // Index width of the storage array; a single-entry array still needs one bit.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int rd_lat(input int out_reg);
        return (out_reg != 0) ? 2 : 1;
    endfunction

endpackage

// File: rtl/sram_1rw_masked_init_if.sv
// Request/response bundle for the single read/write port of sram_1rw_masked_init.
// Handshake: a request is taken at a posedge exactly when RW0_en && ready; there is no
// backpressure beyond ready, and RW0_rvalid is a one-cycle pulse with RW0_rdata held after it.
interface sram_1rw_masked_init_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14,
    parameter int MASK_W = 4
);
    logic [ADDR_W-1:0] RW0_addr;
    logic              RW0_en;
    logic              RW0_wmode;
    logic [MASK_W-1:0] RW0_wmask;
    logic [DATA_W-1:0] RW0_wdata;
    logic [DATA_W-1:0] RW0_rdata;
    logic              RW0_rvalid;
    logic              ready;

    modport master (
        output RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata,
        input  RW0_rdata, RW0_rvalid, ready
    );

    modport slave (
        input  RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata,
        output RW0_rdata, RW0_rvalid, ready
    );
endinterface

// File: rtl/sram_array_core.sv
// Pure storage: segment-masked write and registered read on one address, no reset.
// Callers keep addr within 0..DEPTH-1 whenever we or re is high.
module sram_array_core
    import sram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 16384,
    parameter int MASK_W = 4,
    localparam int IDX_W = idx_w(DEPTH),
    localparam int SEG_W = seg_w(DATA_W, MASK_W)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  addr,
    input  logic [MASK_W-1:0] wmask,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rd_data
);

    if (IDX_W > ADDR_W) begin : g_bad_depth
        $error("DEPTH does not fit in ADDR_W address bits");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < MASK_W; k++) begin
                if (wmask[k]) begin
                    mem_q[addr][k*SEG_W +: SEG_W] <= wdata[k*SEG_W +: SEG_W];
                end
            end
        end
        if (re) begin
            rd_data_q <= mem_q[addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sram_1rw_masked_init.sv
// 1RW SRAM wrapper: zero-sweep after reset, range check, masked writes, read pipeline of
// one or two stages with held read data and a one-cycle rvalid pulse.
module sram_1rw_masked_init
    import sram_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 14,
    parameter int DEPTH    = 16384,
    parameter int MASK_W   = 4,
    parameter int OUT_REG  = 0,
    parameter int CLEAR_EN = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    sram_1rw_masked_init_if.slave rw0,
    output sram_state_e           dbg_state
);

    localparam int SEG_W  = seg_w(DATA_W, MASK_W);
    localparam int IDX_W  = idx_w(DEPTH);
    localparam int RD_LAT = rd_lat(OUT_REG);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam sram_state_e       RST_STATE = (CLEAR_EN != 0) ? ST_CLEAR : ST_RUN;

    if (SEG_W * MASK_W != DATA_W) begin : g_bad_mask
        $error("DATA_W must be an exact multiple of MASK_W");
    end

    sram_state_e      state_q, state_d;
    logic [IDX_W-1:0] clr_ptr_q, clr_ptr_d;
    logic             ready_q, ready_d;
    logic             rv1_q, rv1_d;
    logic             zero1_q, zero1_d;

    logic              in_range, rd_take, wr_take, clearing;
    logic              core_we, core_re;
    logic [IDX_W-1:0]  core_addr;
    logic [MASK_W-1:0] core_wmask;
    logic [DATA_W-1:0] core_wdata, core_rd, stage1_data;

    assign in_range = ({1'b0, rw0.RW0_addr} < DEPTH_LIM);
    assign rd_take  = ready_q & rw0.RW0_en & ~rw0.RW0_wmode;
    assign wr_take  = ready_q & rw0.RW0_en & rw0.RW0_wmode & in_range;
    assign clearing = (state_q == ST_CLEAR);

    // The sweep owns the core while clearing; the reset edge itself never touches the array.
    assign core_we    = reset_n & (clearing | wr_take);
    assign core_re    = reset_n & rd_take & in_range;
    assign core_addr  = clearing ? clr_ptr_q : rw0.RW0_addr[IDX_W-1:0];
    assign core_wmask = clearing ? {MASK_W{1'b1}} : rw0.RW0_wmask;
    assign core_wdata = clearing ? '0 : rw0.RW0_wdata;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        ready_d   = ready_q;
        case (state_q)
            ST_CLEAR: begin
                clr_ptr_d = clr_ptr_q + IDX_W'(1);
                if (clr_ptr_q == LAST_IDX) begin
                    state_d   = ST_RUN;
                    clr_ptr_d = '0;
                    ready_d   = 1'b1;
                end
            end
            ST_RUN:  ready_d = 1'b1;
            default: state_d = ST_RUN;
        endcase
        rv1_d   = rd_take;
        // Out-of-range reads complete with zero data; the flag also masks the unreset core output.
        zero1_d = rd_take ? ~in_range : zero1_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= RST_STATE;
            clr_ptr_q <= '0;
            ready_q   <= 1'b0;
            rv1_q     <= 1'b0;
            zero1_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            ready_q   <= ready_d;
            rv1_q     <= rv1_d;
            zero1_q   <= zero1_d;
        end
    end

    sram_array_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .MASK_W (MASK_W)
    ) u_core (
        .clk     (clock),
        .we      (core_we),
        .re      (core_re),
        .addr    (core_addr),
        .wmask   (core_wmask),
        .wdata   (core_wdata),
        .rd_data (core_rd)
    );

    assign stage1_data = zero1_q ? '0 : core_rd;

    if (RD_LAT == 2) begin : g_out_reg
        logic              rv2_q, rv2_d;
        logic [DATA_W-1:0] rdata2_q, rdata2_d;

        always_comb begin
            rv2_d    = rv1_q;
            rdata2_d = rdata2_q;
            if (rv1_q) begin
                rdata2_d = stage1_data;
            end
        end

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                rv2_q    <= 1'b0;
                rdata2_q <= '0;
            end else begin
                rv2_q    <= rv2_d;
                rdata2_q <= rdata2_d;
            end
        end

        assign rw0.RW0_rdata  = rdata2_q;
        assign rw0.RW0_rvalid = rv2_q;
    end else begin : g_no_out_reg
        assign rw0.RW0_rdata  = stage1_data;
        assign rw0.RW0_rvalid = rv1_q;
    end

    assign rw0.ready = ready_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_1rw_masked_init.sv
// Bench driving four SRAM configurations from one shared request stream and checking them
// against an array-plus-pending-queue reference model.
module tb_sram_1rw_masked_init;
    import sram_pkg::*;

    // Configurations: a = 16/lat1/clear, b = 16/lat2/clear, c = 12/lat1/clear, d = 16/lat2/no clear
    localparam int DEP [4] = '{16, 16, 12, 16};
    localparam int LAT [4] = '{1, 2, 1, 2};
    localparam int CLR [4] = '{1, 1, 1, 0};

    logic        clock;
    logic        reset_n;
    logic        req_en;
    logic        req_wm;
    logic [3:0]  req_addr;
    logic [3:0]  req_mask;
    logic [31:0] req_data;

    sram_1rw_masked_init_if #(.DATA_W(32), .ADDR_W(4), .MASK_W(4)) if_a ();
    sram_1rw_masked_init_if #(.DATA_W(32), .ADDR_W(4), .MASK_W(4)) if_b ();
    sram_1rw_masked_init_if #(.DATA_W(32), .ADDR_W(4), .MASK_W(4)) if_c ();
    sram_1rw_masked_init_if #(.DATA_W(32), .ADDR_W(4), .MASK_W(4)) if_d ();

    sram_state_e dbg_a, dbg_b, dbg_c, dbg_d;

    assign if_a.RW0_addr = req_addr;  assign if_a.RW0_en = req_en;  assign if_a.RW0_wmode = req_wm;
    assign if_a.RW0_wmask = req_mask; assign if_a.RW0_wdata = req_data;
    assign if_b.RW0_addr = req_addr;  assign if_b.RW0_en = req_en;  assign if_b.RW0_wmode = req_wm;
    assign if_b.RW0_wmask = req_mask; assign if_b.RW0_wdata = req_data;
    assign if_c.RW0_addr = req_addr;  assign if_c.RW0_en = req_en;  assign if_c.RW0_wmode = req_wm;
    assign if_c.RW0_wmask = req_mask; assign if_c.RW0_wdata = req_data;
    assign if_d.RW0_addr = req_addr;  assign if_d.RW0_en = req_en;  assign if_d.RW0_wmode = req_wm;
    assign if_d.RW0_wmask = req_mask; assign if_d.RW0_wdata = req_data;

    sram_1rw_masked_init #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .MASK_W(4), .OUT_REG(0), .CLEAR_EN(1))
        u_a (.clock(clock), .reset_n(reset_n), .rw0(if_a), .dbg_state(dbg_a));
    sram_1rw_masked_init #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .MASK_W(4), .OUT_REG(1), .CLEAR_EN(1))
        u_b (.clock(clock), .reset_n(reset_n), .rw0(if_b), .dbg_state(dbg_b));
    sram_1rw_masked_init #(.DATA_W(32), .ADDR_W(4), .DEPTH(12), .MASK_W(4), .OUT_REG(0), .CLEAR_EN(1))
        u_c (.clock(clock), .reset_n(reset_n), .rw0(if_c), .dbg_state(dbg_c));
    sram_1rw_masked_init #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .MASK_W(4), .OUT_REG(1), .CLEAR_EN(0))
        u_d (.clock(clock), .reset_n(reset_n), .rw0(if_d), .dbg_state(dbg_d));

    logic [31:0] obs_rdata  [4];
    logic        obs_rvalid [4];
    logic        obs_ready  [4];
    assign obs_rdata[0] = if_a.RW0_rdata; assign obs_rvalid[0] = if_a.RW0_rvalid; assign obs_ready[0] = if_a.ready;
    assign obs_rdata[1] = if_b.RW0_rdata; assign obs_rvalid[1] = if_b.RW0_rvalid; assign obs_ready[1] = if_b.ready;
    assign obs_rdata[2] = if_c.RW0_rdata; assign obs_rvalid[2] = if_c.RW0_rvalid; assign obs_ready[2] = if_c.ready;
    assign obs_rdata[3] = if_d.RW0_rdata; assign obs_rvalid[3] = if_d.RW0_rvalid; assign obs_ready[3] = if_d.ready;

    // clock/reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // reference model
    typedef struct {
        int          k;
        int          due;
        logic [31:0] data;
        bit          known;
    } pend_t;

    logic [31:0] mem_m     [4][16];
    bit          known_m   [4][16];
    int          run_cnt   [4];
    logic [31:0] exp_rdata [4];
    bit          exp_known [4];
    bit          exp_rvalid[4];
    pend_t       pq[$];
    int          cyc;
    int          n_pass;
    int          n_chk;

    function automatic bit ready_m(input int k);
        return run_cnt[k] >= ((CLR[k] != 0) ? DEP[k] : 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit rst_n, input bit en, input bit wm, input logic [3:0] a,
                              input logic [3:0] m, input logic [31:0] d);
        int ai;
        ai = int'(a);
        cyc++;
        for (int k = 0; k < 4; k++) begin
            exp_rvalid[k] = 1'b0;
            if (!rst_n) begin
                run_cnt[k]   = 0;
                exp_rdata[k] = '0;
                exp_known[k] = 1'b1;
            end else begin
                if (ready_m(k) && en) begin
                    if (wm) begin
                        if (ai < DEP[k]) begin
                            for (int s = 0; s < 4; s++) begin
                                if (m[s]) mem_m[k][ai][s*8 +: 8] = d[s*8 +: 8];
                            end
                            if (m == 4'hF) known_m[k][ai] = 1'b1;
                        end
                    end else begin
                        pend_t p;
                        p.k     = k;
                        p.due   = cyc + LAT[k] - 1;
                        p.data  = (ai < DEP[k]) ? mem_m[k][ai] : 32'h0;
                        p.known = (ai < DEP[k]) ? known_m[k][ai] : 1'b1;
                        pq.push_back(p);
                    end
                end
                if (run_cnt[k] < 100000) run_cnt[k]++;
                if (CLR[k] != 0 && run_cnt[k] == DEP[k]) begin
                    for (int i = 0; i < 16; i++) begin
                        mem_m[k][i]   = '0;
                        known_m[k][i] = 1'b1;
                    end
                end
            end
        end
        if (!rst_n) begin
            pq.delete();
        end else begin
            int i;
            i = 0;
            while (i < pq.size()) begin
                if (pq[i].due == cyc) begin
                    exp_rvalid[pq[i].k] = 1'b1;
                    exp_rdata[pq[i].k]  = pq[i].data;
                    exp_known[pq[i].k]  = pq[i].known;
                    pq.delete(i);
                end else begin
                    i++;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ready[%0d]@%0d", k, cyc), 32'(obs_ready[k]), 32'(ready_m(k)));
            chk($sformatf("rvalid[%0d]@%0d", k, cyc), 32'(obs_rvalid[k]), 32'(exp_rvalid[k]));
            if (exp_known[k]) begin
                chk($sformatf("rdata[%0d]@%0d", k, cyc), obs_rdata[k], exp_rdata[k]);
            end
        end
    endtask

    // driver tasks
    task automatic step(input bit rst_n, input bit en, input bit wm, input logic [3:0] a,
                        input logic [3:0] m, input logic [31:0] d);
        reset_n  = rst_n;
        req_en   = en;
        req_wm   = wm;
        req_addr = a;
        req_mask = m;
        req_data = d;
        @(posedge clock);
        model_edge(rst_n, en, wm, a, m, d);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] m, input logic [31:0] d);
        step(1'b1, 1'b1, 1'b1, a, m, d);
    endtask

    task automatic rd(input logic [3:0] a);
        step(1'b1, 1'b1, 1'b0, a, 4'h0, $urandom);
    endtask

    initial begin
        cyc = 0; n_pass = 0; n_chk = 0;
        for (int k = 0; k < 4; k++) begin
            run_cnt[k] = 0; exp_rdata[k] = '0; exp_known[k] = 1'b0; exp_rvalid[k] = 1'b0;
            for (int i = 0; i < 16; i++) begin
                mem_m[k][i] = '0; known_m[k][i] = 1'b0;
            end
        end
        reset_n = 1'b0; req_en = 1'b0; req_wm = 1'b0; req_addr = '0; req_mask = '0; req_data = '0;

        step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 4'h2, 4'hF, 32'hFFFF_FFFF);

        // Sweep window: a write and a read that only the no-clear instance may accept.
        for (int j = 1; j <= 16; j++) begin
            step(1'b1, (j == 2) || (j == 4), (j == 2), 4'h3, 4'hF, 32'hA5A5_0003);
        end
        chk("ready_after_sweep_a", 32'(obs_ready[0]), 32'd1);

        for (int a = 0; a < 16; a++) rd(4'(a));
        idle(2);

        wr(4'h5, 4'hF, 32'hDEAD_BEEF);
        wr(4'h5, 4'h5, 32'h1122_3344);
        rd(4'h5);
        chk("t2_rdata_lat1", obs_rdata[0], 32'hDE22_BE44);
        chk("t2_rvalid_lat1", 32'(obs_rvalid[0]), 32'd1);
        chk("t2_rvalid_lat2_early", 32'(obs_rvalid[1]), 32'd0);
        idle(1);
        chk("t2_rdata_lat2", obs_rdata[1], 32'hDE22_BE44);
        chk("t2_rvalid_lat2", 32'(obs_rvalid[1]), 32'd1);

        for (int a = 1; a <= 3; a++) wr(4'(a), 4'hF, $urandom);
        for (int a = 1; a <= 3; a++) rd(4'(a));
        idle(3);

        wr(4'hD, 4'hF, 32'h1234_5678);
        rd(4'hD);
        chk("t4_oor_rdata", obs_rdata[2], 32'h0);
        chk("t4_oor_rvalid", 32'(obs_rvalid[2]), 32'd1);
        for (int a = 12; a < 16; a++) wr(4'(a), 4'hF, $urandom);
        for (int a = 0; a < 12; a++) rd(4'(a));
        idle(2);

        for (int i = 0; i < 300; i++) begin
            step(1'b1, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
        end
        idle(2);

        // Reset with a read in flight, then again part-way through the sweep.
        rd(4'h7);
        step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        idle(7);
        step(1'b0, 1'b1, 1'b0, 4'h1, 4'h0, 32'h0);
        for (int j = 1; j <= 16; j++) begin
            step(1'b1, (j == 3), 1'b1, 4'h9, 4'hF, 32'h5A5A_5A5A);
        end
        for (int a = 0; a < 16; a++) rd(4'(a));
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
